// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Purpose : halt encoding default, fetch-buffer entry layout, control FSM states.
// Ports   : none (package).

package fetch_pkg;

   // beq x0,x0,0 : a branch to itself, used as the halt marker.
   localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0063;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HALT  = 2'd1,
      ERR   = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - IMEM, redirect, decode-handshake and status bundle
//
// Purpose : groups every non-clock/reset signal of the fetch stage.
// Modports:
//   master - environment side (IMEM model, branch unit, decode)
//   slave  - fetch stage side (ifetch_unit)
// Signals : imem_addr/imem_rdata (IMEM), redirect_valid/redirect_pc (redirect),
//           if_valid/if_ready/if_instr/if_pc/if_pc_plus4 (decode),
//           halted/misalign_err (status).

interface ifetch_unit_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        halted;
   logic        misalign_err;

   modport master (
      input  imem_addr,
      output imem_rdata,
      output redirect_valid,
      output redirect_pc,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc,
      input  if_pc_plus4,
      input  halted,
      input  misalign_err
   );

   modport slave (
      output imem_addr,
      input  imem_rdata,
      input  redirect_valid,
      input  redirect_pc,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc,
      output if_pc_plus4,
      output halted,
      output misalign_err
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - registered-output synchronous FIFO of fetch entries
//
// Purpose : buffers {pc, instr} pairs between IMEM capture and decode.
// Ports   :
//   clk, rst_n  clock, asynchronous active-low reset
//   push_i      write data_i at the tail
//   pop_i       discard the head
//   flush_i     drop all entries (overrides push/pop)
//   data_i      entry to write
//   full_o      DEPTH entries held
//   empty_o     no entries held
//   head_o      oldest entry (straight from storage, no path from data_i)
//   count_o     number of entries held

module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t data_i,
   output logic         full_o,
   output logic         empty_o,
   output fetch_entry_t head_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // A push into a full FIFO is only accepted alongside a pop: the slot
   // being freed is the one written.
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign do_push = push_i && (!full_o || do_pop) && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (!do_push && do_pop) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction-fetch stage: PC, halt/error FSM, fetch buffer
//
// Purpose : drives the IMEM address from the PC, captures {pc, instr} into a
//           small FIFO feeding decode, and handles redirects, halt and
//           misaligned-target errors.
// Ports   :
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ifetch_unit_if.slave (IMEM, redirect, decode handshake, status)

module ifetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   ifetch_unit_if.slave  bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          misalign_q, misalign_d;
   logic          halted;
   logic          push, pop;
   logic          redirect_aligned;
   logic          is_halt_word;

   fetch_entry_t  fifo_in, fifo_head;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          unused_fifo_full;

   assign redirect_aligned = (bus.redirect_pc[1:0] == 2'b00);
   assign is_halt_word     = (bus.imem_rdata == HALT_INSTR);
   assign pop              = !fifo_empty && bus.if_ready;
   assign push             = !halted && !bus.redirect_valid &&
                             ((fifo_count < CW'(FIFO_DEPTH)) || pop);

   assign fifo_in.pc       = pc_q;
   assign fifo_in.instr    = bus.imem_rdata;
   assign unused_fifo_full = fifo_full;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (bus.redirect_valid),
      .data_i  (fifo_in),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   // Control FSM: state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Control FSM: next state. A redirect outranks a same-cycle halt push.
   always_comb begin
      state_d = state_q;
      if (bus.redirect_valid) begin
         state_d = redirect_aligned ? FETCH : ERR;
      end else if (push && is_halt_word) begin
         state_d = HALT;
      end
   end

   // Control FSM: outputs.
   always_comb begin
      halted = (state_q != FETCH);
   end

   // PC and sticky misalignment flag.
   always_comb begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
      if (bus.redirect_valid) begin
         if (redirect_aligned) pc_d       = bus.redirect_pc;
         else                  misalign_d = 1'b1;
      end else if (push && !is_halt_word) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.imem_addr    = pc_q;
   assign bus.if_valid     = !fifo_empty;
   assign bus.if_instr     = fifo_head.instr;
   assign bus.if_pc        = fifo_head.pc;
   assign bus.if_pc_plus4  = fifo_head.pc + 32'd4;
   assign bus.halted       = halted;
   assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard testbench for ifetch_unit

module tb_ifetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] HALT_W = 32'h0000_0063;
   localparam logic [31:0] NO_HALT = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ifetch_unit_if bus ();

   ifetch_unit #(
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (2),
      .HALT_INSTR (HALT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // IMEM model: addi-like words carrying the address, halt word at
   // halt_addr and anywhere out of range.
   logic [31:0] halt_addr;
   always_comb begin
      if (bus.imem_addr == halt_addr || bus.imem_addr >= 32'h100)
         bus.imem_rdata = HALT_W;
      else
         bus.imem_rdata = {bus.imem_addr[11:0], 20'h00013};
   end

   function automatic logic [31:0] word_at(input logic [31:0] a, input logic [31:0] h);
      if (a == h || a >= 32'h100) return HALT_W;
      return {a[11:0], 20'h00013};
   endfunction

   fetch_entry_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic expect_pc(input logic [31:0] pc);
      fetch_entry_t e;
      e.pc    = pc;
      e.instr = word_at(pc, halt_addr);
      exp_q.push_back(e);
   endtask

   // Called at a negedge; samples first, then advances. Returns the number
   // of cycles advanced before the n-th accepted entry was seen.
   task automatic drain(input string tag, input int n, input int budget, output int cycles);
      fetch_entry_t e;
      int got;
      got = 0;
      cycles = 0;
      while (1) begin
         if (bus.if_valid && bus.if_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra got pc=%h exp no entry", tag, bus.if_pc);
            end else begin
               e = exp_q.pop_front();
               if (bus.if_pc !== e.pc || bus.if_instr !== e.instr ||
                   bus.if_pc_plus4 !== e.pc + 32'd4) begin
                  errors++;
                  $display("FAIL %s_entry got pc=%h instr=%h pc4=%h exp pc=%h instr=%h pc4=%h",
                           tag, bus.if_pc, bus.if_instr, bus.if_pc_plus4,
                           e.pc, e.instr, e.pc + 32'd4);
               end
            end
            got++;
         end
         if (got >= n || cycles >= budget) break;
         @(negedge clk);
         cycles++;
      end
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL %s_timeout got %0d entries exp %0d", tag, got, n);
      end
   endtask

   task automatic do_reset(input logic ready);
      @(negedge clk);
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.if_ready       = 1'b0;
      halt_addr          = NO_HALT;
      exp_q.delete();
      repeat (2) @(negedge clk);
      bus.if_ready = ready;
      rst_n        = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b instr=%h pc=%h exp v=0 instr=0 pc=0",
                  bus.if_valid, bus.if_instr, bus.if_pc);
      end
      checks++;
      if (bus.halted !== 1'b0 || bus.misalign_err !== 1'b0 || bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_status got h=%b m=%b addr=%h exp h=0 m=0 addr=0",
                  bus.halted, bus.misalign_err, bus.imem_addr);
      end
   endtask

   task automatic test_sequential();
      int cyc;
      do_reset(1'b1);
      for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
      drain("seq", 8, 20, cyc);
      checks++;
      if (cyc !== 8) begin
         errors++;
         $display("FAIL seq_throughput got %0d cycles exp 8", cyc);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      do_reset(1'b0);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== word_at(32'h0, NO_HALT)) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got v=%b pc=%h instr=%h exp v=1 pc=0 instr=%h",
                     i, bus.if_valid, bus.if_pc, bus.if_instr, word_at(32'h0, NO_HALT));
         end
      end
      checks++;
      if (bus.imem_addr !== 32'h8) begin
         errors++;
         $display("FAIL bp_addr got %h exp 00000008", bus.imem_addr);
      end
      bus.if_ready = 1'b1;
      for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
      drain("bp", 4, 10, cyc);
      checks++;
      if (cyc !== 3) begin
         errors++;
         $display("FAIL bp_release got %0d cycles exp 3", cyc);
      end
   endtask

   task automatic test_redirect_full();
      int cyc;
      do_reset(1'b0);
      repeat (3) @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
         errors++;
         $display("FAIL redir_flush got v=%b addr=%h exp v=0 addr=00000040",
                  bus.if_valid, bus.imem_addr);
      end
      bus.if_ready = 1'b1;
      expect_pc(32'h40);
      expect_pc(32'h44);
      drain("redir", 2, 10, cyc);
   endtask

   task automatic test_halt();
      int cyc;
      do_reset(1'b1);
      halt_addr = 32'h10;
      for (int i = 0; i < 5; i++) expect_pc(32'(i * 4));
      drain("halt", 5, 20, cyc);
      checks++;
      if (bus.halted !== 1'b1 || bus.imem_addr !== 32'h10) begin
         errors++;
         $display("FAIL halt_state got h=%b addr=%h exp h=1 addr=00000010",
                  bus.halted, bus.imem_addr);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL halt_stopped got v=%b addr=%h exp v=0 addr=00000010",
                     bus.if_valid, bus.imem_addr);
         end
      end
      halt_addr          = NO_HALT;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.halted !== 1'b0 || bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL halt_resume got h=%b addr=%h exp h=0 addr=00000000",
                  bus.halted, bus.imem_addr);
      end
      expect_pc(32'h0);
      expect_pc(32'h4);
      drain("halt_resume", 2, 10, cyc);
   endtask

   task automatic test_misaligned();
      int cyc;
      do_reset(1'b0);
      repeat (3) @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h22;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.misalign_err !== 1'b1 || bus.halted !== 1'b1 ||
          bus.imem_addr !== 32'h8 || bus.if_valid !== 1'b0) begin
         errors++;
         $display("FAIL mis_err got m=%b h=%b addr=%h v=%b exp m=1 h=1 addr=00000008 v=0",
                  bus.misalign_err, bus.halted, bus.imem_addr, bus.if_valid);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.imem_addr !== 32'h8 || bus.if_valid !== 1'b0) begin
         errors++;
         $display("FAIL mis_stopped got addr=%h v=%b exp addr=00000008 v=0",
                  bus.imem_addr, bus.if_valid);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.halted !== 1'b0 || bus.misalign_err !== 1'b1 || bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL mis_sticky got h=%b m=%b addr=%h exp h=0 m=1 addr=00000000",
                  bus.halted, bus.misalign_err, bus.imem_addr);
      end
      bus.if_ready = 1'b1;
      expect_pc(32'h0);
      expect_pc(32'h4);
      drain("mis_resume", 2, 10, cyc);
   endtask

   task automatic test_async_reset();
      do_reset(1'b0);
      halt_addr = 32'h4;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.if_valid !== 1'b1 || bus.halted !== 1'b1 || bus.imem_addr !== 32'h4) begin
         errors++;
         $display("FAIL arst_pre got v=%b h=%b addr=%h exp v=1 h=1 addr=00000004",
                  bus.if_valid, bus.halted, bus.imem_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.if_valid !== 1'b0 || bus.halted !== 1'b0 ||
          bus.imem_addr !== 32'h0 || bus.if_pc !== 32'h0) begin
         errors++;
         $display("FAIL arst_now got v=%b h=%b addr=%h pc=%h exp v=0 h=0 addr=0 pc=0",
                  bus.if_valid, bus.halted, bus.imem_addr, bus.if_pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.if_ready       = 1'b0;
      halt_addr          = NO_HALT;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_full();
      test_halt();
      test_misaligned();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
